target_direction_tracker: RTL and testbench

//  Upstream feeder of the LCD status display. Consumes the per-pixel target-match stream from the camera

---
 rtl/target_direction_tracker.sv | 171 +++++++++++++++++
 tb/tb_target_direction_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/target_direction_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : target_direction_tracker                                         |
// | Purpose : per-frame x-centroid of target-matched pixels -> bearing (deg)   |
// |           -> hysteresis-filtered 3-bit steering command for the display.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module target_direction_tracker #(
  parameter int FOV           = 25,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int MIN_PIXELS    = 64,
  parameter int STABLE_FRAMES = 3,
  localparam int DIR_W        = $clog2(FOV) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             pix_sop,
  input  logic             pix_eop,
  input  logic             pix_match,
  output logic [2:0]       command,
  output logic [DIR_W-1:0] direction,
  output logic             target_present,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W  = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam int SUM_W  = $clog2(IMG_WIDTH * IMG_WIDTH * IMG_HEIGHT);
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int WIDE_W = SUM_W + DIR_W + 1;
  localparam int STEP_W = $clog2(DIR_W);
  localparam int STAB_W = $clog2(STABLE_FRAMES + 1);
  localparam int T1     = 1 * FOV / 5;
  localparam int T2     = 2 * FOV / 5;
  localparam int T3     = 3 * FOV / 5;
  localparam int T4     = 4 * FOV / 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_in_frame, r_close;
  logic [COL_W-1:0]   r_col, w_col_beat;
  logic [SUM_W-1:0]   r_sum, w_sum_base;
  logic [CNT_W-1:0]   r_cnt, w_cnt_base, r_cnt_snap;
  logic [WIDE_W-1:0]  r_num, r_den, w_trial;
  logic [DIR_W-1:0]   r_quot;
  logic [STEP_W-1:0]  r_step;
  logic               w_take, w_discard, w_load, w_fits, w_present;
  logic [2:0]         r_pending, w_cand;
  logic [STAB_W-1:0]  r_stable, w_stab_next;

  // A frame closing while a divide is running (or about to start) is dropped.
  assign w_take     = pix_valid && (pix_sop || r_in_frame);
  assign w_discard  = (r_state == S_DIVIDE) || r_close;
  assign w_col_beat = pix_sop ? '0 :
                      (r_col == COL_W'(IMG_WIDTH - 1)) ? '0 : r_col + COL_W'(1);
  assign w_sum_base = pix_sop ? '0 : r_sum;
  assign w_cnt_base = pix_sop ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_frame <= 1'b0;
      r_close    <= 1'b0;
      r_col      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
    end else begin
      r_close <= 1'b0;
      if (w_take) begin
        r_col      <= w_col_beat;
        r_sum      <= w_sum_base + (pix_match ? SUM_W'(w_col_beat) : '0);
        r_cnt      <= w_cnt_base + CNT_W'(pix_match);
        r_in_frame <= !pix_eop;
        r_close    <= pix_eop && !w_discard;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_close) begin
          w_load       = 1'b1;
          w_state_next = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        busy = 1'b1;
        if (r_step == '0) w_state_next = S_RESULT;
      end
      S_RESULT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Restoring divide, quotient bits produced MSB first.
  assign w_trial = r_den << r_step;
  assign w_fits  = (r_num >= w_trial);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num      <= '0;
      r_den      <= '0;
      r_quot     <= '0;
      r_step     <= '0;
      r_cnt_snap <= '0;
    end else if (w_load) begin
      r_num      <= WIDE_W'(r_sum) * WIDE_W'(FOV);
      r_den      <= WIDE_W'(r_cnt) * WIDE_W'(IMG_WIDTH);
      r_cnt_snap <= r_cnt;
      r_quot     <= '0;
      r_step     <= STEP_W'(DIR_W - 1);
    end else if (r_state == S_DIVIDE) begin
      if (w_fits) r_num <= r_num - w_trial;
      r_quot <= {r_quot[DIR_W-2:0], w_fits};
      r_step <= r_step - STEP_W'(1);
    end
  end

  always_comb begin
    w_present   = (r_cnt_snap >= CNT_W'(MIN_PIXELS));
    w_cand      = 3'd0;
    w_stab_next = STAB_W'(1);
    if (w_present) begin
      if      (r_quot < DIR_W'(T1)) w_cand = 3'd1;
      else if (r_quot < DIR_W'(T2)) w_cand = 3'd2;
      else if (r_quot < DIR_W'(T3)) w_cand = 3'd3;
      else if (r_quot < DIR_W'(T4)) w_cand = 3'd4;
      else                          w_cand = 3'd5;
    end
    if (w_cand == r_pending)
      w_stab_next = (r_stable >= STAB_W'(STABLE_FRAMES)) ? r_stable : r_stable + STAB_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      command        <= 3'd0;
      direction      <= '0;
      target_present <= 1'b0;
      frame_done     <= 1'b0;
      r_pending      <= 3'd0;
      r_stable       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (r_state == S_RESULT) begin
        frame_done     <= 1'b1;
        r_pending      <= w_cand;
        r_stable       <= w_stab_next;
        target_present <= w_present;
        if (w_present) direction <= r_quot;
        if (w_stab_next >= STAB_W'(STABLE_FRAMES)) command <= w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_target_direction_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_target_direction_tracker                                      |
// | Purpose : directed frames with a result scoreboard for the tracker.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_target_direction_tracker;

  localparam int FOV   = 25;
  localparam int W     = 20;
  localparam int H     = 4;
  localparam int MINP  = 2;
  localparam int SF    = 2;
  localparam int DIR_W = $clog2(FOV) + 1;
  localparam int LAT   = DIR_W + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0, pix_match = 1'b0;
  logic [2:0]       command;
  logic [DIR_W-1:0] direction;
  logic             target_present, frame_done, busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {int cmd; int dir; int tp; int cyc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int m_pend = 0, m_stab = 0, m_cmd = 0, m_dir = 0;

  target_direction_tracker #(
    .FOV(FOV), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(MINP), .STABLE_FRAMES(SF)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop), .pix_match(pix_match),
    .command(command), .direction(direction), .target_present(target_present),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("sb_command", {29'd0, command}, mon_e.cmd);
        check("sb_direction", {{(32-DIR_W){1'b0}}, direction}, mon_e.dir);
        check("sb_target_present", {31'd0, target_present}, mon_e.tp);
      end
    end
  end

  task automatic model_result(input int sum, input int cnt, input int eop_edge);
    int q, cand, tp;
    exp_t e;
    cand = 0;
    tp = 0;
    if (cnt >= MINP) begin
      q = (sum * FOV) / (cnt * W);
      tp = 1;
      m_dir = q;
      if      (q < 1 * FOV / 5) cand = 1;
      else if (q < 2 * FOV / 5) cand = 2;
      else if (q < 3 * FOV / 5) cand = 3;
      else if (q < 4 * FOV / 5) cand = 4;
      else                      cand = 5;
    end
    if (cand == m_pend) m_stab = (m_stab + 1 > SF) ? SF : m_stab + 1;
    else begin
      m_pend = cand;
      m_stab = 1;
    end
    if (m_stab >= SF) m_cmd = m_pend;
    e.cmd = m_cmd; e.dir = m_dir; e.tp = tp; e.cyc = eop_edge + LAT;
    sb.push_back(e);
  endtask

  // Matches sit at column mcol on the first nlines lines (mcol<0: none).
  task automatic send_frame(input int mcol, input int nlines, input int nbeats,
                            input bit close, input bit expect_out);
    int sum, cnt, eop_edge, col, line;
    bit m;
    sum = 0; cnt = 0; eop_edge = 0;
    for (int b = 0; b < nbeats; b++) begin
      col  = b % W;
      line = b / W;
      m    = (col == mcol) && (line < nlines);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_sop   = (b == 0);
      pix_eop   = close && (b == nbeats - 1);
      pix_match = m;
      if (m) begin
        sum += col;
        cnt++;
      end
      eop_edge = cyc + 1;
    end
    if (close && expect_out) model_result(sum, cnt, eop_edge);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0; pix_match = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    idle(1);
    while (sb.size() != 0 && k < LAT + 20) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    check("rst_command", {29'd0, command}, 0);
    check("rst_direction", {{(32-DIR_W){1'b0}}, direction}, 0);
    check("rst_target_present", {31'd0, target_present}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    idle(2);

    repeat (3) begin
      send_frame(10, 4, W * H, 1, 1);
      wait_drain();
    end
    check("centre_command", {29'd0, command}, 3);
    check("centre_direction", {{(32-DIR_W){1'b0}}, direction}, 12);

    send_frame(0, 4, W * H, 1, 1);  wait_drain();
    send_frame(0, 4, W * H, 1, 1);  wait_drain();
    check("hard_left_command", {29'd0, command}, 1);
    send_frame(19, 4, W * H, 1, 1); wait_drain();
    check("edge_direction", {{(32-DIR_W){1'b0}}, direction}, 23);
    check("edge_command_held", {29'd0, command}, 1);

    send_frame(10, 4, W * H, 1, 1); wait_drain();
    send_frame(10, 4, W * H, 1, 1); wait_drain();
    send_frame(10, 1, W * H, 1, 1); wait_drain();
    check("lost_present", {31'd0, target_present}, 0);
    check("lost_direction_hold", {{(32-DIR_W){1'b0}}, direction}, 12);
    check("lost_command_once", {29'd0, command}, 3);
    send_frame(10, 1, W * H, 1, 1); wait_drain();
    check("lost_command_twice", {29'd0, command}, 0);

    send_frame(3, 4, 30, 0, 0);
    send_frame(15, 4, W * H, 1, 1);
    wait_drain();
    check("restart_direction", {{(32-DIR_W){1'b0}}, direction}, 18);

    send_frame(10, 4, W * H, 1, 1);
    send_frame(-1, 4, 2, 1, 0);
    wait_drain();
    idle(LAT + 4);

    send_frame(10, 4, W * H, 1, 0);
    idle(2);
    check("busy_mid_divide", {31'd0, busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_command", {29'd0, command}, 0);
    check("abort_direction", {{(32-DIR_W){1'b0}}, direction}, 0);
    check("abort_target_present", {31'd0, target_present}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_frame_done", {31'd0, frame_done}, 0);
    reset = 1'b0;
    m_pend = 0; m_stab = 0; m_cmd = 0; m_dir = 0;
    idle(LAT + 4);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; pix_sop = 1'b0; pix_eop = (i == 4); pix_match = 1'b1;
    end
    idle(LAT + 4);
    send_frame(-1, 4, W * H, 1, 1);
    wait_drain();
    check("empty_present", {31'd0, target_present}, 0);
    check("empty_command", {29'd0, command}, 0);
    check("empty_direction", {{(32-DIR_W){1'b0}}, direction}, 0);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
